hex_scan_counter: RTL

- Upstream feeder for the active-low 7-segment hex decoder: a 16-bit prescaled up/down hex counter with synchronous load.
- Time-multiplexes its four nibbles onto one 4-bit digit bus and drives active-low anode selects.
- Asserts a blank flag for suppressed leading zeros; the flag drives the decoder's blanking input directly.
- One decoder instance therefore serves a 4-digit display.

---
 rtl/hex_scan_counter_if.sv | 23 ++
 rtl/hex_scan_counter.sv | 106 ++++++++++
 2 files changed

// File: rtl/hex_scan_counter_if.sv
// Control and display bus of the hex scan counter: count controls in, count and
// multiplexed digit/anode/blank out toward a single 7-segment decoder.
interface hex_scan_counter_if;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] cnt;
  logic        tick;
  logic [0:3]  digit;
  logic [0:3]  an;
  logic        blank;

  modport master (
    output en, up, load, load_val,
    input  cnt, tick, digit, an, blank
  );

  modport slave (
    input  en, up, load, load_val,
    output cnt, tick, digit, an, blank
  );
endinterface

// File: rtl/hex_scan_counter.sv
// Prescaled 16-bit up/down hex counter with synchronous load, time-multiplexing
// its four nibbles onto one digit bus with anode selects and leading-zero blanking.
module hex_scan_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high despite the name
  hex_scan_counter_if.slave bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    slot_q, slot_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      scan_q  <= '0;
      slot_q  <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      scan_q  <= scan_d;
      slot_q  <= slot_d;
    end
  end

  // Load beats a coincident step and restarts the prescaler.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (bus.load) begin
      cnt_d   = bus.load_val;
      presc_d = '0;
    end else if (bus.en) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        cnt_d   = bus.up ? cnt_q + 16'd1 : cnt_q - 16'd1;
      end else begin
        presc_d = presc_q + TW'(1);
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    slot_d = slot_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  logic [3:0] nib [4];
  logic [3:0] nib_zero;

  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign nib[gi]      = cnt_q[4*gi +: 4];
    assign nib_zero[gi] = (cnt_q[4*gi +: 4] == 4'h0);
  end

  logic [3:0] an_val;
  logic       blank_val;

  // Blank only when this nibble and every more significant one are zero.
  always_comb begin
    an_val    = 4'b1110;
    blank_val = 1'b0;
    case (slot_q)
      2'd0: begin
        an_val    = 4'b1110;
        blank_val = 1'b0;
      end
      2'd1: begin
        an_val    = 4'b1101;
        blank_val = &nib_zero[3:1];
      end
      2'd2: begin
        an_val    = 4'b1011;
        blank_val = &nib_zero[3:2];
      end
      default: begin
        an_val    = 4'b0111;
        blank_val = nib_zero[3];
      end
    endcase
  end

  assign bus.cnt   = cnt_q;
  assign bus.tick  = tick_q;
  assign bus.digit = nib[slot_q];
  assign bus.an    = an_val;
  assign bus.blank = blank_val;
endmodule
